// File: rtl/rps_arbiter.sv
// rps_arbiter: DMA channel arbiter with rotating or fixed priority.
// Ports: clk, rst (sync, active-high), en, rot_mode, req/mask [NCH],
//   done -> grant [NCH] one-hot, grant_id, busy, hi_ptr (priority head).
module rps_arbiter #(
   parameter int NCH = 4,
   parameter int IDW = $clog2(NCH)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic           rot_mode,
   input  logic [NCH-1:0] req,
   input  logic [NCH-1:0] mask,
   input  logic           done,
   output logic [NCH-1:0] grant,
   output logic [IDW-1:0] grant_id,
   output logic           busy,
   output logic [IDW-1:0] hi_ptr
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_OWN  = 1'b1
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [NCH-1:0] r_grant;
   logic [NCH-1:0] w_grant_nxt;
   logic [IDW-1:0] r_gid;
   logic [IDW-1:0] w_gid_nxt;
   logic [IDW-1:0] r_hi;
   logic [IDW-1:0] w_hi_nxt;

   logic [NCH-1:0] w_elig;
   logic [IDW-1:0] w_start;
   logic [IDW-1:0] w_rot;
   logic [IDW-1:0] w_win_id;
   logic           w_win_vld;
   logic [IDW:0]   w_sum;

   assign w_elig  = req & ~mask;
   assign w_start = rot_mode ? r_hi : '0;
   assign w_rot   = (r_gid == IDW'(NCH - 1)) ? '0 : r_gid + 1'b1;

   // Circular scan from w_start; index wraps explicitly so NCH
   // need not be a power of two.
   always_comb begin
      w_win_vld = 1'b0;
      w_win_id  = '0;
      w_sum     = '0;
      for (int i = 0; i < NCH; i++) begin
         w_sum = {1'b0, w_start} + (IDW + 1)'(i);
         if (w_sum >= (IDW + 1)'(NCH))
            w_sum = w_sum - (IDW + 1)'(NCH);
         if (!w_win_vld && w_elig[w_sum[IDW-1:0]]) begin
            w_win_vld = 1'b1;
            w_win_id  = w_sum[IDW-1:0];
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_grant <= '0;
         r_gid   <= '0;
         r_hi    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_gid   <= w_gid_nxt;
         r_hi    <= w_hi_nxt;
      end
   end

   // Next-state logic; a disable aborts without rotating the pointer
   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_gid_nxt   = r_gid;
      w_hi_nxt    = r_hi;
      if (!en) begin
         w_state_nxt = S_IDLE;
         w_grant_nxt = '0;
         w_gid_nxt   = '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_win_vld) begin
                  w_state_nxt           = S_OWN;
                  w_grant_nxt           = '0;
                  w_grant_nxt[w_win_id] = 1'b1;
                  w_gid_nxt             = w_win_id;
               end
            end
            S_OWN: begin
               if (done) begin
                  w_state_nxt = S_IDLE;
                  w_grant_nxt = '0;
                  w_gid_nxt   = '0;
                  if (rot_mode)
                     w_hi_nxt = w_rot;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_grant_nxt = '0;
               w_gid_nxt   = '0;
            end
         endcase
      end
   end

   // Outputs
   always_comb begin
      grant    = r_grant;
      grant_id = r_gid;
      busy     = (r_state == S_OWN);
      hi_ptr   = r_hi;
   end

endmodule

// File: tb/tb_rps_arbiter.sv
// tb_rps_arbiter: directed NCH=4 checks plus randomized NCH=8 run
// against a behavioural model, with fairness checks.
module tb_rps_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       en4, rm4, done4, busy4;
   logic [3:0] req4, mask4, g4;
   logic [1:0] gid4, hp4;
   logic       en8, rm8, done8, busy8;
   logic [7:0] req8, mask8, g8;
   logic [2:0] gid8, hp8;

   int n_chk  = 0;
   int n_fail = 0;

   rps_arbiter #(.NCH(4)) u_dut4 (
      .clk(clk), .rst(rst), .en(en4), .rot_mode(rm4),
      .req(req4), .mask(mask4), .done(done4),
      .grant(g4), .grant_id(gid4), .busy(busy4), .hi_ptr(hp4)
   );

   rps_arbiter #(.NCH(8)) u_dut8 (
      .clk(clk), .rst(rst), .en(en8), .rot_mode(rm8),
      .req(req8), .mask(mask8), .done(done8),
      .grant(g8), .grant_id(gid8), .busy(busy8), .hi_ptr(hp8)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_rst();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // Behavioural model of the 8-channel instance
   logic m_own;
   int   m_gid;
   int   m_hi;
   bit   chk8_en = 1'b0;

   function automatic int pick8(input logic [7:0] e, input int s);
      int idx;
      for (int k = 0; k < 8; k++) begin
         idx = (s + k) % 8;
         if (e[idx[2:0]]) return idx;
      end
      return -1;
   endfunction

   always @(posedge clk) begin : model
      int w;
      if (rst) begin
         m_own <= 1'b0;
         m_gid <= 0;
         m_hi  <= 0;
      end else if (!en8) begin
         m_own <= 1'b0;
         m_gid <= 0;
      end else if (m_own) begin
         if (done8) begin
            m_own <= 1'b0;
            m_gid <= 0;
            if (rm8) m_hi <= (m_gid + 1) % 8;
         end
      end else begin
         w = pick8(req8 & ~mask8, rm8 ? m_hi : 0);
         if (w >= 0) begin
            m_own <= 1'b1;
            m_gid <= w;
         end
      end
   end

   always @(negedge clk) begin
      if (chk8_en) begin
         chk("g8", 32'(g8), m_own ? (1 << m_gid) : 0);
         chk("gid8", 32'(gid8), m_gid);
         chk("busy8", 32'(busy8), 32'(m_own));
         chk("hp8", 32'(hp8), m_hi);
         chk("onehot8", 32'($onehot0(g8)), 1);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int  cnt;
      bit  found;
      rst   = 1'b1;
      en4   = 1'b1;
      rm4   = 1'b1;
      req4  = 4'hF;
      mask4 = 4'h0;
      done4 = 1'b0;
      en8   = 1'b0;
      rm8   = 1'b0;
      req8  = 8'h0;
      mask8 = 8'h0;
      done8 = 1'b0;
      tick();
      tick();
      chk("rst_grant", 32'(g4), 0);
      chk("rst_gid", 32'(gid4), 0);
      chk("rst_busy", 32'(busy4), 0);
      chk("rst_hp", 32'(hp4), 0);
      chk8_en = 1'b1;
      rst = 1'b0;

      // rotating order 0,1,2,3,0
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("rot_grant", 32'(g4), 1 << (k % 4));
         chk("rot_gid", 32'(gid4), k % 4);
         chk("rot_busy", 32'(busy4), 1);
         done4 = 1'b1;
         tick();
         chk("rot_rel_grant", 32'(g4), 0);
         chk("rot_rel_busy", 32'(busy4), 0);
         chk("rot_hp", 32'(hp4), (k + 1) % 4);
         done4 = 1'b0;
      end

      // fixed priority
      do_rst();
      rm4  = 1'b0;
      req4 = 4'b1010;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("fix_grant", 32'(g4), 2);
         chk("fix_gid", 32'(gid4), 1);
         done4 = 1'b1;
         tick();
         chk("fix_rel", 32'(g4), 0);
         chk("fix_hp", 32'(hp4), 0);
         done4 = 1'b0;
      end

      // grant holds regardless of req/mask/mode
      do_rst();
      rm4  = 1'b1;
      req4 = 4'b0100;
      tick();
      chk("lat_grant", 32'(g4), 4);
      chk("lat_gid", 32'(gid4), 2);
      chk("lat_busy", 32'(busy4), 1);
      req4  = 4'h0;
      mask4 = 4'hF;
      rm4   = 1'b0;
      repeat (3) begin
         tick();
         chk("hold_grant", 32'(g4), 4);
      end
      rm4   = 1'b1;
      done4 = 1'b1;
      tick();
      chk("rel_grant", 32'(g4), 0);
      chk("rel_gid", 32'(gid4), 0);
      chk("rel_busy", 32'(busy4), 0);
      chk("rel_hp", 32'(hp4), 3);
      mask4 = 4'h0;
      repeat (3) begin
         tick();
         chk("idle_done_busy", 32'(busy4), 0);
         chk("idle_done_hp", 32'(hp4), 3);
      end
      done4 = 1'b0;

      // all masked, then unmask ch3
      req4  = 4'hF;
      mask4 = 4'hF;
      repeat (4) begin
         tick();
         chk("masked_grant", 32'(g4), 0);
      end
      mask4 = 4'b0111;
      tick();
      chk("unmask_grant", 32'(g4), 8);
      chk("unmask_gid", 32'(gid4), 3);

      // disable mid-OWN, then reset mid-OWN
      en4 = 1'b0;
      tick();
      chk("dis_grant", 32'(g4), 0);
      chk("dis_busy", 32'(busy4), 0);
      chk("dis_gid", 32'(gid4), 0);
      chk("dis_hp", 32'(hp4), 3);
      en4 = 1'b1;
      tick();
      chk("reen_grant", 32'(g4), 8);
      rst = 1'b1;
      tick();
      chk("mid_rst_grant", 32'(g4), 0);
      chk("mid_rst_gid", 32'(gid4), 0);
      chk("mid_rst_busy", 32'(busy4), 0);
      chk("mid_rst_hp", 32'(hp4), 0);
      rst = 1'b0;

      // randomized 8-channel run
      repeat (1500) begin
         rst   = ($urandom_range(0, 299) == 0);
         en8   = ($urandom_range(0, 19) != 0);
         if ($urandom_range(0, 9) == 0) rm8 = ~rm8;
         req8  = 8'($urandom);
         mask8 = 8'($urandom & $urandom & $urandom);
         done8 = ($urandom_range(0, 2) == 0);
         tick();
      end
      rst = 1'b0;

      // fairness: persistent channel p served within 8 grants
      rm8   = 1'b1;
      en8   = 1'b1;
      done8 = 1'b0;
      for (int p = 0; p < 8; p++) begin
         cnt   = 0;
         found = 1'b0;
         for (int c = 0; c < 60 && !found; c++) begin
            req8  = 8'($urandom) | (8'd1 << p);
            mask8 = 8'($urandom & $urandom) & ~(8'd1 << p);
            tick();
            if (busy8) begin
               cnt++;
               if (32'(gid8) == p) found = 1'b1;
               done8 = 1'b1;
            end else begin
               done8 = 1'b0;
            end
         end
         chk("fair_found", 32'(found), 1);
         chk("fair_cnt_le8", 32'(cnt <= 8), 1);
      end
      done8 = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rps_arbiter.md
RPS_ARBITER -- requirements
Module: rps_arbiter

Interface
REQ-001 Parameter NCH, default 4, number of DMA channels; legal values 2..16.
REQ-002 Parameter IDW, default $clog2(NCH), width of grant_id.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  arbiter enable; low forces idle.
REQ-006 rot_mode  input  1  priority mode: 1 = rotating, 0 = fixed (channel 0 highest).
REQ-007 req  input  NCH  per-channel service request, level-sensitive.
REQ-008 mask  input  NCH  per-channel mask; 1 blocks that channel.
REQ-009 done  input  1  current owner releases the grant.
REQ-010 grant  output  NCH  registered one-hot grant.
REQ-011 grant_id  output  IDW  binary index of the granted channel; 0 when idle.
REQ-012 busy  output  1  high while any grant is held.
REQ-013 hi_ptr  output  IDW  index of the current highest-priority channel.

Function
REQ-014 States SHALL be IDLE (no grant) and OWN (one grant held).
REQ-015 Eligible vector SHALL be req & ~mask, sampled in IDLE only.
REQ-016 In IDLE with en=1 and eligible nonzero, the winner SHALL be the first eligible channel scanning upward from hi_ptr, modulo NCH.
REQ-017 In fixed mode (rot_mode=0), scan start SHALL be channel 0 regardless of hi_ptr.
REQ-018 Grant latency SHALL be 1 cycle: eligible sampled at edge t, grant/grant_id/busy valid after edge t+1, state OWN.
REQ-019 In OWN, grant SHALL hold stable until done=1, independent of req, mask and rot_mode changes.
REQ-020 On done=1 in OWN: next cycle grant=0, busy=0, grant_id=0, state IDLE.
REQ-021 Minimum one IDLE cycle between consecutive grants; earliest re-grant is 2 cycles after the done edge.
REQ-022 On done in OWN with rot_mode=1, hi_ptr SHALL become (grant_id+1) mod NCH; when grant_id=NCH-1, hi_ptr wraps to 0.
REQ-023 On done with rot_mode=0, hi_ptr SHALL be unchanged.
REQ-024 done in IDLE SHALL be ignored.
REQ-025 en=0 SHALL force state IDLE, grant=0, busy=0, grant_id=0 next cycle, including mid-OWN; hi_ptr unchanged.
REQ-026 A grant aborted by en=0 SHALL NOT rotate hi_ptr.
REQ-027 All-masked or zero req in IDLE SHALL leave outputs at idle values.
REQ-028 grant SHALL never have more than one bit set; grant_id SHALL always equal the index of the set bit.

Reset
REQ-029 rst=1 at a clock edge SHALL set state IDLE, grant=0, grant_id=0, busy=0, hi_ptr=0.
REQ-030 rst SHALL take priority over en, done and req, including mid-OWN.
REQ-031 First arbitration after rst deassertion SHALL be evaluated at the first edge with rst=0.

Verification
REQ-032 NCH=4, rot_mode=1, req=4'b1111 held, done pulsed 1 cycle after each grant -> grant order 0,1,2,3,0; hi_ptr sequence 1,2,3,0.
REQ-033 NCH=4, rot_mode=0, req=4'b1010, repeated done -> grant always 4'b0010; hi_ptr stays 0.
REQ-034 req=4'b0100 at edge t -> grant=4'b0100, grant_id=2, busy=1 after edge t+1; req dropped while done=0 -> grant still 4'b0100.
REQ-035 mask=4'b1111, req=4'b1111 -> grant=0 indefinitely; clear mask[3] -> grant=4'b1000 one cycle later.
REQ-036 In OWN with grant_id=3: drive en=0 -> grant=0 next cycle, hi_ptr unchanged; drive rst=1 -> all outputs 0, hi_ptr=0.
REQ-037 NCH=8 parametrised run with random req/mask/done/en -> assertions REQ-019, REQ-021, REQ-028 hold; every persistently eligible channel is granted within 8 grants in rotating mode.
